// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : Circular store FIFO that drains one entry at a time to
//                memory through a req/ack handshake. Optional store-to-load
//                forwarding is built when STORE_BUFFER_FORWARD_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          store_buffer_write_en,
  input  logic [AW-1:0] store_buffer_address,
  input  logic [DW-1:0] store_buffer_data,
  input  logic          load_lookup,
  output logic          store_buffer_full,
  output logic          store_buffer_empty,
  output logic [DW-1:0] store_buffer_read_data,
  output logic          store_buffer_read_valid,
  output logic          mem_req,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data,
  input  logic          mem_ack
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] head_q, head_d;
  logic [IW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_address_q, mem_address_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [AW-1:0] addr_mem_d [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [DW-1:0] data_mem_d [DEPTH];
  logic          push;
  logic          pop;

  // Flags come from the registered count, so a pop cannot free a slot for a
  // push in the same cycle.
  assign store_buffer_full  = (count_q == C_DEPTH);
  assign store_buffer_empty = (count_q == '0);
  assign push               = store_buffer_write_en && !store_buffer_full;

  // FIFO storage and pointer/count bookkeeping.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      addr_mem_d[tail_q] = store_buffer_address;
      data_mem_d[tail_q] = store_buffer_data;
      tail_d             = tail_q + IW'(1);
    end
    if (pop) begin
      head_d = head_q + IW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Drain FSM: issue the head entry, hold it until acked, then pop it.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    pop           = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          mem_req_d     = 1'b1;
          mem_address_d = addr_mem_q[head_q];
          mem_data_d    = data_mem_q[head_q];
          state_d       = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (mem_ack) begin
          pop       = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage array needs no reset; only entries between head and tail matter.
  always_ff @(posedge clk) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
  end

  // Control registers; reset abandons any in-flight drain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      mem_req_q     <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      mem_req_q     <= mem_req_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;

`ifdef STORE_BUFFER_FORWARD_EN
  logic          hit;
  logic [DW-1:0] hit_data;
  logic [IW-1:0] idx;
  logic          read_valid_q, read_valid_d;
  logic [DW-1:0] read_data_q, read_data_d;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + IW'(i);
      if ((CW'(i) < count_q) && (addr_mem_q[idx] == store_buffer_address)) begin
        hit      = 1'b1;
        hit_data = data_mem_q[idx];
      end
    end
  end

  // Lookup result is registered; read_data holds when no lookup is made.
  always_comb begin
    read_valid_d = load_lookup && hit;
    read_data_d  = load_lookup ? hit_data : read_data_q;
  end

  // Forwarding result registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      read_valid_q <= 1'b0;
      read_data_q  <= '0;
    end else begin
      read_valid_q <= read_valid_d;
      read_data_q  <= read_data_d;
    end
  end

  assign store_buffer_read_valid = read_valid_q;
  assign store_buffer_read_data  = read_data_q;
`else
  logic unused_lookup;

  assign unused_lookup           = load_lookup;
  assign store_buffer_read_valid = 1'b0;
  assign store_buffer_read_data  = '0;
`endif

endmodule
`default_nettype wire
